stream_arb_mux_n: RTL and testbench

- Registered, handshaked successor to the team's combinational N-way mux.
- Selects one of NUM_INPUTS valid/ready streams per beat and forwards it through a one-entry output register.
- Three selection modes: round-robin, fixed-priority, external select.
- Packet locking on i_last prevents interleaving beats of different packets.
- Used between GPU command/data producers and a shared downstream consumer.

---
 rtl/stream_arb_mux_n.sv | 146 ++++++++++++++
 tb/tb_stream_arb_mux_n.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arb_mux_n.sv
// N-way valid/ready stream arbiter feeding a one-entry output register.
// Round-robin, fixed-priority or externally selected, with packet locking on i_last.
module stream_arb_mux_n #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MODE       = 0,
    parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [NUM_INPUTS-1:0]                i_valid,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] i_data,
    input  logic [NUM_INPUTS-1:0]                i_last,
    output logic [NUM_INPUTS-1:0]                o_ready,
    input  logic [SEL_W-1:0]                     i_sel,
    output logic                                 o_valid,
    output logic [DATA_WIDTH-1:0]                o_data,
    output logic                                 o_last,
    output logic [SEL_W-1:0]                     o_src,
    input  logic                                 i_ready
);

    generate
        if (NUM_INPUTS < 2) begin : g_bad_num_inputs
            $fatal(1, "stream_arb_mux_n: NUM_INPUTS must be >= 2");
        end
        if (MODE > 2 || MODE < 0) begin : g_bad_mode
            $fatal(1, "stream_arb_mux_n: MODE must be 0, 1 or 2");
        end
    endgenerate

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_INPUTS - 1);
    localparam logic [SEL_W:0]   NUM_EXT  = (SEL_W + 1)'(NUM_INPUTS);

    logic                  o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0] o_data_q,  o_data_d;
    logic                  o_last_q,  o_last_d;
    logic [SEL_W-1:0]      o_src_q,   o_src_d;
    logic [SEL_W-1:0]      rr_ptr_q,  rr_ptr_d;
    logic                  locked_q,  locked_d;
    logic [SEL_W-1:0]      lock_idx_q, lock_idx_d;

    logic [SEL_W-1:0]      cand;
    logic                  has_cand;
    logic                  space;
    logic                  grant;
    logic [SEL_W:0]        rr_sum;
    logic [SEL_W-1:0]      rr_idx;

    assign space = !o_valid_q || i_ready;

    always_comb begin
        cand     = '0;
        has_cand = 1'b0;
        rr_sum   = '0;
        rr_idx   = '0;
        if (locked_q) begin
            cand     = lock_idx_q;
            has_cand = 1'b1;
        end else if (MODE == 2) begin
            cand     = i_sel;
            has_cand = ({1'b0, i_sel} < NUM_EXT);
        end else if (MODE == 1) begin
            // Descending scan so the lowest valid index is the last one written.
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                if (i_valid[SEL_W'(k)]) begin
                    cand     = SEL_W'(k);
                    has_cand = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
                rr_sum = {1'b0, rr_ptr_q} + (SEL_W + 1)'(k);
                if (rr_sum >= NUM_EXT) begin
                    rr_sum = rr_sum - NUM_EXT;
                end
                rr_idx = rr_sum[SEL_W-1:0];
                if (!has_cand && i_valid[rr_idx]) begin
                    cand     = rr_idx;
                    has_cand = 1'b1;
                end
            end
        end
    end

    // Reset gates the grant so o_ready is low for as long as i_rst_n is held.
    assign grant = i_rst_n && has_cand && i_valid[cand] && space;

    always_comb begin
        o_ready = '0;
        if (grant) begin
            o_ready[cand] = 1'b1;
        end
    end

    always_comb begin
        o_valid_d  = o_valid_q;
        o_data_d   = o_data_q;
        o_last_d   = o_last_q;
        o_src_d    = o_src_q;
        rr_ptr_d   = rr_ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        if (grant) begin
            o_valid_d = 1'b1;
            o_data_d  = i_data[cand];
            o_last_d  = i_last[cand];
            o_src_d   = cand;
            locked_d  = !i_last[cand];
            if (!i_last[cand]) begin
                lock_idx_d = cand;
            end
            if (MODE == 0 && i_last[cand]) begin
                rr_ptr_d = (cand == LAST_IDX) ? '0 : cand + SEL_W'(1);
            end
        end else if (o_valid_q && i_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_last_q   <= 1'b0;
            o_src_q    <= '0;
            rr_ptr_q   <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            o_last_q   <= o_last_d;
            o_src_q    <= o_src_d;
            rr_ptr_q   <= rr_ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_last  = o_last_q;
    assign o_src   = o_src_q;

endmodule

// File: tb/tb_stream_arb_mux_n.sv
// Directed bench for stream_arb_mux_n: four instances (RR, priority, select N=4, select N=3)
// share stimulus; a scoreboard queue holds the expected output beats.
module tb_stream_arb_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [3:0]       drive_valid;
    logic [3:0][31:0] drive_data;
    logic [3:0]       drive_last;
    logic [1:0]       drive_sel;
    logic             drive_ready;
    int               cur;

    logic [3:0] v0, v1, v2;
    logic [2:0] v3;
    logic [3:0] ir;
    logic [3:0] ordy0, ordy1, ordy2;
    logic [2:0] ordy3;
    logic        ov [4];
    logic [31:0] od [4];
    logic        ol [4];
    logic [1:0]  os [4];

    assign v0 = (cur == 0) ? drive_valid : 4'b0;
    assign v1 = (cur == 1) ? drive_valid : 4'b0;
    assign v2 = (cur == 2) ? drive_valid : 4'b0;
    assign v3 = (cur == 3) ? drive_valid[2:0] : 3'b0;
    assign ir = drive_ready ? (4'b0001 << cur) : 4'b0000;

    stream_arb_mux_n #(.NUM_INPUTS(4), .DATA_WIDTH(32), .MODE(0)) u_rr (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .i_data(drive_data), .i_last(drive_last),
        .o_ready(ordy0), .i_sel(drive_sel), .o_valid(ov[0]), .o_data(od[0]), .o_last(ol[0]),
        .o_src(os[0]), .i_ready(ir[0]));

    stream_arb_mux_n #(.NUM_INPUTS(4), .DATA_WIDTH(32), .MODE(1)) u_prio (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .i_data(drive_data), .i_last(drive_last),
        .o_ready(ordy1), .i_sel(drive_sel), .o_valid(ov[1]), .o_data(od[1]), .o_last(ol[1]),
        .o_src(os[1]), .i_ready(ir[1]));

    stream_arb_mux_n #(.NUM_INPUTS(4), .DATA_WIDTH(32), .MODE(2)) u_sel4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .i_data(drive_data), .i_last(drive_last),
        .o_ready(ordy2), .i_sel(drive_sel), .o_valid(ov[2]), .o_data(od[2]), .o_last(ol[2]),
        .o_src(os[2]), .i_ready(ir[2]));

    stream_arb_mux_n #(.NUM_INPUTS(3), .DATA_WIDTH(32), .MODE(2)) u_sel3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v3), .i_data(drive_data[2:0]),
        .i_last(drive_last[2:0]), .o_ready(ordy3), .i_sel(drive_sel), .o_valid(ov[3]),
        .o_data(od[3]), .o_last(ol[3]), .o_src(os[3]), .i_ready(ir[3]));

    logic        mo_valid;
    logic [31:0] mo_data;
    logic        mo_last;
    logic [1:0]  mo_src;
    logic [3:0]  mo_ready;

    always_comb begin
        mo_valid = 1'b0;
        mo_data  = '0;
        mo_last  = 1'b0;
        mo_src   = '0;
        mo_ready = '0;
        case (cur)
            0: begin mo_valid = ov[0]; mo_data = od[0]; mo_last = ol[0]; mo_src = os[0]; mo_ready = ordy0; end
            1: begin mo_valid = ov[1]; mo_data = od[1]; mo_last = ol[1]; mo_src = os[1]; mo_ready = ordy1; end
            2: begin mo_valid = ov[2]; mo_data = od[2]; mo_last = ol[2]; mo_src = os[2]; mo_ready = ordy2; end
            default: begin
                mo_valid = ov[3]; mo_data = od[3]; mo_last = ol[3]; mo_src = os[3];
                mo_ready = {1'b0, ordy3};
            end
        endcase
    end

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    typedef struct packed {
        logic [1:0]  src;
        logic        last;
        logic [31:0] data;
    } exp_t;

    beat_t      src_q [4][$];
    exp_t       exp_q [$];
    int         checks = 0;
    int         errors = 0;
    int         n_xfer = 0;
    logic [3:0] smp_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (src_q[k].size() > 0) begin
                drive_valid[k] = 1'b1;
                drive_data[k]  = src_q[k][0].data;
                drive_last[k]  = src_q[k][0].last;
            end else begin
                drive_valid[k] = 1'b0;
                drive_data[k]  = '0;
                drive_last[k]  = 1'b0;
            end
        end
    endtask

    task automatic send(input int k, input logic [31:0] d, input logic l);
        beat_t b;
        b.last = l;
        b.data = d;
        src_q[k].push_back(b);
    endtask

    task automatic expect_beat(input int s, input logic [31:0] d, input logic l);
        exp_t e;
        e.src  = 2'(s);
        e.last = l;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock: sample at the falling edge, retire accepted beats after the rising edge.
    task automatic tick();
        logic [3:0] hs;
        exp_t       e;
        @(negedge clk);
        smp_ready = mo_ready;
        hs = drive_valid & mo_ready;
        if (mo_valid && drive_ready) begin
            n_xfer++;
            chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_src", 32'(mo_src), 32'(e.src));
                chk("sb_data", mo_data, e.data);
                chk("sb_last", 32'(mo_last), 32'(e.last));
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k] && src_q[k].size() > 0) begin
                void'(src_q[k].pop_front());
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) src_q[k].delete();
        exp_q.delete();
        drive();
        n_xfer = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        cur         = 0;
        drive_sel   = 2'd0;
        drive_ready = 1'b1;
        drive();
        do_reset();

        chk("rst_valid", 32'(mo_valid), 32'd0);
        chk("rst_data",  mo_data, 32'd0);
        chk("rst_last",  32'(mo_last), 32'd0);
        chk("rst_src",   32'(mo_src), 32'd0);
        chk("rst_ready", 32'(mo_ready), 32'd0);

        // Round-robin, every stream valid with single-beat packets.
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 4; k++) begin
                send(k, 32'h1000_0000 | 32'(k << 8) | 32'(j), 1'b1);
                expect_beat(k, 32'h1000_0000 | 32'(k << 8) | 32'(j), 1'b1);
            end
        end
        drive();
        repeat (9) tick();
        chk("rr_one_per_cycle", 32'(n_xfer), 32'd8);
        chk("rr_drain", 32'(exp_q.size()), 32'd0);

        // Round-robin packet lock: stream 2 holds the grant against stream 0.
        do_reset();
        send(1, 32'h0000_1111, 1'b1);
        expect_beat(1, 32'h0000_1111, 1'b1);
        drive();
        tick();
        send(2, 32'h0000_2220, 1'b0);
        send(2, 32'h0000_2221, 1'b0);
        send(2, 32'h0000_2222, 1'b1);
        send(0, 32'h0000_0001, 1'b1);
        expect_beat(2, 32'h0000_2220, 1'b0);
        expect_beat(2, 32'h0000_2221, 1'b0);
        expect_beat(2, 32'h0000_2222, 1'b1);
        expect_beat(0, 32'h0000_0001, 1'b1);
        drive();
        tick();
        chk("lock_first", 32'(smp_ready), 32'b0100);
        tick();
        chk("lock_hold_a", 32'(smp_ready), 32'b0100);
        tick();
        chk("lock_hold_b", 32'(smp_ready), 32'b0100);
        tick();
        chk("lock_release", 32'(smp_ready), 32'b0001);
        tick();
        tick();
        chk("lock_drain", 32'(exp_q.size()), 32'd0);

        // Fixed priority, then a locked bubble on stream 3.
        cur = 1;
        do_reset();
        send(1, 32'h0000_00A1, 1'b1);
        send(3, 32'h0000_00A3, 1'b1);
        expect_beat(1, 32'h0000_00A1, 1'b1);
        expect_beat(3, 32'h0000_00A3, 1'b1);
        drive();
        tick();
        chk("prio_low_wins", 32'(smp_ready), 32'b0010);
        tick();
        chk("prio_next", 32'(smp_ready), 32'b1000);
        tick();
        send(3, 32'h0000_00B0, 1'b0);
        expect_beat(3, 32'h0000_00B0, 1'b0);
        drive();
        tick();
        send(0, 32'h0000_00C0, 1'b1);
        drive();
        tick();
        chk("bubble_a", 32'(smp_ready), 32'd0);
        tick();
        chk("bubble_b", 32'(smp_ready), 32'd0);
        send(3, 32'h0000_00B1, 1'b1);
        expect_beat(3, 32'h0000_00B1, 1'b1);
        expect_beat(0, 32'h0000_00C0, 1'b1);
        drive();
        tick();
        chk("bubble_end", 32'(smp_ready), 32'b1000);
        tick();
        chk("prio_after_lock", 32'(smp_ready), 32'b0001);
        tick();
        chk("prio_drain", 32'(exp_q.size()), 32'd0);

        // External select, four streams.
        cur = 2;
        do_reset();
        drive_sel = 2'd3;
        send(3, 32'h0000_00D3, 1'b1);
        send(0, 32'h0000_00D0, 1'b1);
        expect_beat(3, 32'h0000_00D3, 1'b1);
        expect_beat(0, 32'h0000_00D0, 1'b1);
        drive();
        tick();
        chk("sel3_ready", 32'(smp_ready), 32'b1000);
        drive_sel = 2'd0;
        tick();
        chk("sel0_ready", 32'(smp_ready), 32'b0001);
        tick();
        chk("sel_drain", 32'(exp_q.size()), 32'd0);

        // External select, three streams, out-of-range select.
        cur = 3;
        do_reset();
        drive_sel = 2'd3;
        send(0, 32'h0000_00E0, 1'b1);
        send(1, 32'h0000_00E1, 1'b1);
        send(2, 32'h0000_00E2, 1'b1);
        drive();
        repeat (3) begin
            tick();
            chk("oob_ready", 32'(smp_ready), 32'd0);
            chk("oob_valid", 32'(mo_valid), 32'd0);
        end
        drive_sel = 2'd2;
        expect_beat(2, 32'h0000_00E2, 1'b1);
        tick();
        chk("n3_sel2_ready", 32'(smp_ready), 32'b0100);
        tick();
        chk("n3_drain", 32'(exp_q.size()), 32'd0);

        // Backpressure: held beat stays put, then transfer and accept coincide.
        cur = 0;
        do_reset();
        drive_ready = 1'b0;
        send(0, 32'hDEAD_BEEF, 1'b1);
        send(1, 32'h1111_1111, 1'b1);
        send(2, 32'h2222_2222, 1'b1);
        expect_beat(0, 32'hDEAD_BEEF, 1'b1);
        expect_beat(1, 32'h1111_1111, 1'b1);
        expect_beat(2, 32'h2222_2222, 1'b1);
        drive();
        tick();
        repeat (5) begin
            tick();
            chk("bp_ready", 32'(smp_ready), 32'd0);
            chk("bp_valid", 32'(mo_valid), 32'd1);
            chk("bp_data", mo_data, 32'hDEAD_BEEF);
        end
        drive_ready = 1'b1;
        tick();
        chk("bp_resume_accept", 32'(smp_ready), 32'b0010);
        tick();
        tick();
        chk("bp_drain", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with a beat held and another stream waiting.
        do_reset();
        drive_ready = 1'b0;
        send(2, 32'h0000_5A5A, 1'b1);
        drive();
        tick();
        chk("pre_rst_valid", 32'(mo_valid), 32'd1);
        chk("pre_rst_src", 32'(mo_src), 32'd2);
        send(1, 32'h0000_0077, 1'b1);
        drive();
        #2;
        drive_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(mo_valid), 32'd0);
        chk("async_rst_ready", 32'(mo_ready), 32'd0);
        chk("async_rst_src", 32'(mo_src), 32'd0);
        chk("async_rst_data", mo_data, 32'd0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
